// File: rtl/vlc_pkg.sv
// Shared encodings for the lamp-sequencer monitor: modes, lamp patterns, FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package vlc_pkg;

  // Decoded mode encodings
  localparam logic [1:0] MODE_NONE  = 2'b00;
  localparam logic [1:0] MODE_LEFT  = 2'b01;
  localparam logic [1:0] MODE_RIGHT = 2'b10;
  localparam logic [1:0] MODE_EMERG = 2'b11;

  // Lamp patterns as {Left_Lamp, Right_Lamp}
  localparam logic [5:0] PAT_OFF = 6'b000000;
  localparam logic [5:0] PAT_L1  = 6'b100000;
  localparam logic [5:0] PAT_L2  = 6'b110000;
  localparam logic [5:0] PAT_L3  = 6'b111000;
  localparam logic [5:0] PAT_R1  = 6'b000001;
  localparam logic [5:0] PAT_R2  = 6'b000011;
  localparam logic [5:0] PAT_R3  = 6'b000111;
  localparam logic [5:0] PAT_E1  = 6'b100001;
  localparam logic [5:0] PAT_E2  = 6'b110011;
  localparam logic [5:0] PAT_E3  = 6'b111111;

  // Monitor FSM states; E4/E5 are the descending half of the emergency sweep
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_L1, ST_L2, ST_L3,
    ST_R1, ST_R2, ST_R3,
    ST_E1, ST_E2, ST_E3, ST_E4, ST_E5
  } mon_state_e;

endpackage

// File: rtl/vlc_pattern_classify.sv
// Maps a 6-bit lamp pattern to {legal, mode, resync state}; zero and unknown are not legal.
// Latency: combinational.
// Backpressure: none (pure decode).
module vlc_pattern_classify
  import vlc_pkg::*;
(
  input  logic [5:0]  pat,
  output logic        legal,
  output logic [1:0]  pat_mode,
  output mon_state_e  resync_state
);

  // Table lookup; ambiguous emergency patterns resolve to their first occurrence
  always_comb begin
    legal        = 1'b0;
    pat_mode     = MODE_NONE;
    resync_state = ST_IDLE;
    case (pat)
      PAT_L1: begin legal = 1'b1; pat_mode = MODE_LEFT;  resync_state = ST_L1; end
      PAT_L2: begin legal = 1'b1; pat_mode = MODE_LEFT;  resync_state = ST_L2; end
      PAT_L3: begin legal = 1'b1; pat_mode = MODE_LEFT;  resync_state = ST_L3; end
      PAT_R1: begin legal = 1'b1; pat_mode = MODE_RIGHT; resync_state = ST_R1; end
      PAT_R2: begin legal = 1'b1; pat_mode = MODE_RIGHT; resync_state = ST_R2; end
      PAT_R3: begin legal = 1'b1; pat_mode = MODE_RIGHT; resync_state = ST_R3; end
      PAT_E1: begin legal = 1'b1; pat_mode = MODE_EMERG; resync_state = ST_E1; end
      PAT_E2: begin legal = 1'b1; pat_mode = MODE_EMERG; resync_state = ST_E2; end
      PAT_E3: begin legal = 1'b1; pat_mode = MODE_EMERG; resync_state = ST_E3; end
      default: ;
    endcase
  end

endmodule

// File: rtl/vlc_lamp_monitor.sv
// Passive lamp-sequence checker: decodes mode, flags illegal order, counts sweeps/errors.
// Latency: 1 cycle, every output registered from the sample on the same out_newclock edge.
// Backpressure: none; observes only. Define VLC_MON_STICKY_EN to latch err_sticky.
module vlc_lamp_monitor
  import vlc_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int IDLE_HOLD = 2
) (
  input  logic             out_newclock,
  input  logic             rst_n,
  input  logic [2:0]       Left_Lamp,
  input  logic [2:0]       Right_Lamp,
  output logic [1:0]       mode,
  output logic             mode_chg,
  output logic             cycle_done,
  output logic             seq_err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_sticky
);

  localparam logic [3:0] HOLD = 4'(IDLE_HOLD);

  logic [5:0] pat;
  logic       cls_legal;
  logic [1:0] cls_mode;
  mon_state_e cls_state;

  mon_state_e state, state_nxt, exp_state;
  logic [5:0] exp_pat;
  logic       terminal, pat_zero, idle_start, match;
  logic       done_ev, err_ev, timeout;
  logic [3:0] zrun, zrun_nxt;
  logic [1:0] mode_nxt;

  assign pat = {Left_Lamp, Right_Lamp};

  vlc_pattern_classify u_classify (
    .pat          (pat),
    .legal        (cls_legal),
    .pat_mode     (cls_mode),
    .resync_state (cls_state)
  );

  // Successor pattern and state expected from each non-idle state
  always_comb begin
    exp_pat   = PAT_OFF;
    exp_state = ST_IDLE;
    terminal  = 1'b0;
    case (state)
      ST_L1: begin exp_pat = PAT_L2; exp_state = ST_L2; end
      ST_L2: begin exp_pat = PAT_L3; exp_state = ST_L3; end
      ST_L3: terminal = 1'b1;
      ST_R1: begin exp_pat = PAT_R2; exp_state = ST_R2; end
      ST_R2: begin exp_pat = PAT_R3; exp_state = ST_R3; end
      ST_R3: terminal = 1'b1;
      ST_E1: begin exp_pat = PAT_E2; exp_state = ST_E2; end
      ST_E2: begin exp_pat = PAT_E3; exp_state = ST_E3; end
      ST_E3: begin exp_pat = PAT_E2; exp_state = ST_E4; end
      ST_E4: begin exp_pat = PAT_E1; exp_state = ST_E5; end
      ST_E5: terminal = 1'b1;
      default: ;
    endcase
  end

  assign pat_zero   = (pat == PAT_OFF);
  assign idle_start = (pat == PAT_L1) || (pat == PAT_R1) || (pat == PAT_E1);
  assign match      = (state == ST_IDLE) ? (pat_zero || idle_start) : (pat == exp_pat);

  // A mismatching legal pattern in a different mode is a sequencer mode switch, not an error
  assign done_ev = match && terminal;
  assign err_ev  = !match && (!cls_legal || (cls_mode == mode));

  // Next state: follow the sweep, resync onto a known pattern, else fall back to IDLE
  always_comb begin
    if (match)
      state_nxt = (state == ST_IDLE) ? cls_state : exp_state;
    else if (cls_legal)
      state_nxt = cls_state;
    else
      state_nxt = ST_IDLE;
  end

  // Zero-run tracking drops mode to NONE once the lamps stay dark long enough
  always_comb begin
    if (!pat_zero)
      zrun_nxt = 4'd0;
    else if (zrun == HOLD)
      zrun_nxt = zrun;
    else
      zrun_nxt = zrun + 4'd1;
    timeout  = pat_zero && (zrun_nxt == HOLD);
    mode_nxt = timeout ? MODE_NONE : (cls_legal ? cls_mode : mode);
  end

  // FSM state, registered pulses and saturating counters
  always_ff @(posedge out_newclock or posedge rst_n) begin
    if (rst_n) begin
      state      <= ST_IDLE;
      zrun       <= 4'd0;
      mode       <= MODE_NONE;
      mode_chg   <= 1'b0;
      cycle_done <= 1'b0;
      seq_err    <= 1'b0;
      cycle_cnt  <= '0;
      err_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      zrun       <= zrun_nxt;
      mode       <= mode_nxt;
      mode_chg   <= (mode_nxt != mode);
      cycle_done <= done_ev;
      seq_err    <= err_ev;
      if (done_ev && (cycle_cnt != '1))
        cycle_cnt <= cycle_cnt + 1'b1;
      if (err_ev && (err_cnt != '1))
        err_cnt <= err_cnt + 1'b1;
    end
  end

`ifdef VLC_MON_STICKY_EN
  // Latch any sequence error until the next reset
  always_ff @(posedge out_newclock or posedge rst_n) begin
    if (rst_n)
      err_sticky <= 1'b0;
    else if (err_ev)
      err_sticky <= 1'b1;
  end
`else
  assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_vlc_lamp_monitor.sv
// Directed bench for vlc_lamp_monitor: vector table plus reset/saturation sequences.
// Latency: checks outputs 1 ns after the sampling edge.
// Backpressure: n/a.
module tb_vlc_lamp_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] left_l = 3'b000;
  logic [2:0] right_l = 3'b000;

  logic [1:0] mode;
  logic       mode_chg, cycle_done, seq_err, err_sticky;
  logic [7:0] cycle_cnt, err_cnt;

  logic [1:0] s_mode;
  logic       s_mode_chg, s_cycle_done, s_seq_err, s_err_sticky;
  logic [1:0] s_cycle_cnt, s_err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef VLC_MON_STICKY_EN
  localparam logic STICKY_ON = 1'b1;
`else
  localparam logic STICKY_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  vlc_lamp_monitor #(.CNT_W(8), .IDLE_HOLD(2)) u_dut (
    .out_newclock (clk),
    .rst_n        (rst_n),
    .Left_Lamp    (left_l),
    .Right_Lamp   (right_l),
    .mode         (mode),
    .mode_chg     (mode_chg),
    .cycle_done   (cycle_done),
    .seq_err      (seq_err),
    .cycle_cnt    (cycle_cnt),
    .err_cnt      (err_cnt),
    .err_sticky   (err_sticky)
  );

  vlc_lamp_monitor #(.CNT_W(2), .IDLE_HOLD(2)) u_sat (
    .out_newclock (clk),
    .rst_n        (rst_n),
    .Left_Lamp    (left_l),
    .Right_Lamp   (right_l),
    .mode         (s_mode),
    .mode_chg     (s_mode_chg),
    .cycle_done   (s_cycle_done),
    .seq_err      (s_seq_err),
    .cycle_cnt    (s_cycle_cnt),
    .err_cnt      (s_err_cnt),
    .err_sticky   (s_err_sticky)
  );

  typedef struct packed {
    logic [5:0] p;
    logic [1:0] mode;
    logic       chg;
    logic       done;
    logic       err;
    logic [7:0] ccnt;
    logic [7:0] ecnt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [5:0] p, input logic [1:0] m, input logic c, input logic d,
                     input logic e, input int cc, input int ec);
    vec_t v;
    v.p = p; v.mode = m; v.chg = c; v.done = d; v.err = e;
    v.ccnt = 8'(cc); v.ecnt = 8'(ec);
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic step(input logic [5:0] p);
    @(negedge clk);
    {left_l, right_l} = p;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [20:0] outs();
    return {mode, mode_chg, cycle_done, seq_err, cycle_cnt, err_cnt};
  endfunction

  initial begin
    // p, mode, chg, done, err, ccnt, ecnt
    add(6'b000000, 2'd0, 0, 0, 0, 0, 0);
    for (int s = 0; s < 3; s++) begin
      if (s > 0) add(6'b000000, 2'd0, 1, 0, 0, s, 0);   // second zero drops mode
      add(6'b100000, 2'd1, 1, 0, 0, s, 0);
      add(6'b110000, 2'd1, 0, 0, 0, s, 0);
      add(6'b111000, 2'd1, 0, 0, 0, s, 0);
      add(6'b000000, 2'd1, 0, 1, 0, s + 1, 0);
    end
    // emergency sweep then idle timeout
    add(6'b100001, 2'd3, 1, 0, 0, 3, 0);
    add(6'b110011, 2'd3, 0, 0, 0, 3, 0);
    add(6'b111111, 2'd3, 0, 0, 0, 3, 0);
    add(6'b110011, 2'd3, 0, 0, 0, 3, 0);
    add(6'b100001, 2'd3, 0, 0, 0, 3, 0);
    add(6'b000000, 2'd3, 0, 1, 0, 4, 0);
    add(6'b000000, 2'd0, 1, 0, 0, 4, 0);
    // mid-sweep switch LEFT -> EMERG at E2
    add(6'b100000, 2'd1, 1, 0, 0, 4, 0);
    add(6'b110000, 2'd1, 0, 0, 0, 4, 0);
    add(6'b110011, 2'd3, 1, 0, 0, 4, 0);
    add(6'b111111, 2'd3, 0, 0, 0, 4, 0);
    add(6'b110011, 2'd3, 0, 0, 0, 4, 0);
    add(6'b100001, 2'd3, 0, 0, 0, 4, 0);
    add(6'b000000, 2'd3, 0, 1, 0, 5, 0);
    // skip, unknown pattern, unexpected zero, reversal
    add(6'b100000, 2'd1, 1, 0, 0, 5, 0);
    add(6'b111000, 2'd1, 0, 0, 1, 5, 1);
    add(6'b010101, 2'd1, 0, 0, 1, 5, 2);
    add(6'b000001, 2'd2, 1, 0, 0, 5, 2);
    add(6'b000000, 2'd2, 0, 0, 1, 5, 3);
    add(6'b000000, 2'd0, 1, 0, 0, 5, 3);
    add(6'b100001, 2'd3, 1, 0, 0, 5, 3);
    add(6'b110011, 2'd3, 0, 0, 0, 5, 3);
    add(6'b100001, 2'd3, 0, 0, 1, 5, 4);
    add(6'b110011, 2'd3, 0, 0, 0, 5, 4);
    add(6'b000000, 2'd3, 0, 0, 1, 5, 5);
    // resync from IDLE into L3 with a different mode, then complete
    add(6'b111000, 2'd1, 1, 0, 0, 5, 5);
    add(6'b000000, 2'd1, 0, 1, 0, 6, 5);
    add(6'b000000, 2'd0, 1, 0, 0, 6, 5);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", {11'd0, outs(), err_sticky}, 32'd0);
    check("reset_sat", {27'd0, s_mode, s_cycle_cnt, s_err_cnt, s_err_sticky}, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;

    foreach (vq[i]) begin
      step(vq[i].p);
      check($sformatf("vec%0d_p%b", i, vq[i].p), {11'd0, outs()},
            {11'd0, vq[i].mode, vq[i].chg, vq[i].done, vq[i].err, vq[i].ccnt, vq[i].ecnt});
    end
    check("sat_counters", {28'd0, s_cycle_cnt, s_err_cnt}, 32'h0000000F);
    check("sticky_after_errors", {31'd0, err_sticky}, {31'd0, STICKY_ON});

    // synchronous-looking reset pulse clears everything, including sticky
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset2_outs", {11'd0, outs(), err_sticky}, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;

    // five RIGHT sweeps: narrow counter saturates at 3
    for (int s = 0; s < 5; s++) begin
      step(6'b000001);
      step(6'b000011);
      step(6'b000111);
      step(6'b000000);
      check($sformatf("right_done%0d", s), {23'd0, cycle_done, cycle_cnt}, {23'd0, 1'b1, 8'(s + 1)});
    end
    check("right_mode_err", {22'd0, mode, err_cnt}, {22'd0, 2'd2, 8'd0});
    check("right_sat", {30'd0, s_cycle_cnt}, 32'd3);
    check("sticky_clean", {31'd0, err_sticky}, 32'd0);

    // asynchronous reset in the middle of an emergency sweep (at E3)
    step(6'b100001);
    step(6'b110011);
    step(6'b111111);
    #2;
    rst_n = 1'b1;
    #1;
    check("async_reset_outs", {11'd0, outs(), err_sticky}, 32'd0);
    check("async_reset_sat", {27'd0, s_mode, s_cycle_cnt, s_err_cnt, s_err_sticky}, 32'd0);
    rst_n = 1'b0;

    step(6'b111111);
    check("resync_e3", {11'd0, outs()}, {11'd0, 2'd3, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0});
    step(6'b110011);
    check("resync_e4", {11'd0, outs()}, {11'd0, 2'd3, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0});
    step(6'b100001);
    step(6'b000000);
    check("resync_done", {11'd0, outs()}, {11'd0, 2'd3, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
